// File: rtl/drawing_pkg.sv
// Shared types and defaults for the drawing-engine request arbiter.
package drawing_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 255;

  typedef logic [1:0] de_cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/drawing_arbiter_if.sv
// Requester-side and drawing-demux-side handshake bundle for drawing_arbiter.
interface drawing_arbiter_if #(
  parameter int NREQ = drawing_pkg::NREQ_DEF
);
  import drawing_pkg::*;

  logic [NREQ-1:0]   req_i;
  logic [2*NREQ-1:0] cmd_i;
  logic [NREQ-1:0]   ack_o;
  logic              de_req;
  de_cmd_t           de_cmd;
  logic              de_ack;
  logic              busy;
  logic              err;

  modport master (
    input  req_i, cmd_i, de_ack,
    output ack_o, de_req, de_cmd, busy, err
  );

  modport slave (
    output req_i, cmd_i, de_ack,
    input  ack_o, de_req, de_cmd, busy, err
  );

endinterface

// File: rtl/drawing_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module drawing_rr_pick
  import drawing_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int k;
    any = 1'b0;
    gnt = '0;
    idx = '0;
    k   = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/drawing_arbiter.sv
// Round-robin arbiter sharing the drawing-engine four-phase port among NREQ requesters.
// Optional abort-on-stall watchdog enabled by defining DRAWING_ARBITER_TIMEOUT_EN.
module drawing_arbiter
  import drawing_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  drawing_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("drawing_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("drawing_arbiter: TIMEOUT must be in 1..65535");
  end

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [NREQ-1:0]  gnt_oh;

  logic             pick_any;
  logic [NREQ-1:0]  pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             grant_ok;
  logic             to_hit;

  drawing_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (bus.req_i),
    .ptr (ptr),
    .any (pick_any),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

`ifdef DRAWING_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             err_r;

  // A stuck de_ack left over from an aborted transfer must clear before a new grant.
  assign grant_ok = pick_any && !bus.de_ack;
  assign to_hit   = ((state == ISSUE && !bus.de_ack) || (state == RELEASE && bus.de_ack))
                    && (to_cnt == CNT_W'(TIMEOUT - 1));
  assign bus.err  = err_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err_r  <= 1'b0;
    end else begin
      if (state == IDLE || state == DONE || (state == ISSUE && bus.de_ack))
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 1'b1;
      if (to_hit)
        err_r <= 1'b1;
    end
  end
`else
  assign grant_ok = pick_any;
  assign to_hit   = 1'b0;
  assign bus.err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt_idx    <= '0;
      gnt_oh     <= '0;
      bus.ack_o  <= '0;
      bus.de_req <= 1'b0;
      bus.de_cmd <= '0;
      bus.busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ok) begin
            state      <= ISSUE;
            gnt_idx    <= pick_idx;
            gnt_oh     <= pick_gnt;
            bus.de_cmd <= bus.cmd_i[{pick_idx, 1'b0} +: 2];
            bus.de_req <= 1'b1;
            bus.busy   <= 1'b1;
          end
        end
        ISSUE: begin
          if (bus.de_ack) begin
            state      <= RELEASE;
            bus.de_req <= 1'b0;
          end else if (to_hit) begin
            state      <= DONE;
            bus.de_req <= 1'b0;
            bus.ack_o  <= gnt_oh;
          end
        end
        RELEASE: begin
          if (!bus.de_ack || to_hit) begin
            state     <= DONE;
            bus.ack_o <= gnt_oh;
          end
        end
        DONE: begin
          // de_cmd is left holding the last command; it is only reloaded on the next grant.
          if (!(|(bus.req_i & gnt_oh))) begin
            state     <= IDLE;
            bus.ack_o <= '0;
            bus.busy  <= 1'b0;
            if (gnt_idx == IDX_W'(NREQ - 1))
              ptr <= '0;
            else
              ptr <= gnt_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drawing_arbiter.sv
// Directed scoreboard bench for drawing_arbiter (requester and drawing-demux models included).
module tb_drawing_arbiter;
  import drawing_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  drawing_arbiter_if #(.NREQ(NREQ)) bus ();

  drawing_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         idx;
    logic [1:0] cmd;
  } exp_t;
  exp_t sb[$];

  int              add_cnt [NREQ];
  int              done_cnt[NREQ];
  logic [1:0]      cmd_tab [NREQ];
  logic [NREQ-1:0] req_r    = '0;
  logic            ds_ack   = 1'b0;
  logic            hold_ack = 1'b0;
  logic            ds_en    = 1'b1;
  int              ack_dly  = 3;
  int              ds_cnt   = 0;

  assign bus.req_i  = req_r;
  assign bus.de_ack = ds_ack | hold_ack;
  for (genvar g = 0; g < NREQ; g++) begin : g_cmd
    assign bus.cmd_i[2*g +: 2] = cmd_tab[g];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester k raises req while it has outstanding work and drops it once acknowledged.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NREQ; k++) begin
      if (req_r[k] && bus.ack_o[k]) begin
        req_r[k] = 1'b0;
        done_cnt[k]++;
      end else if (!req_r[k] && !bus.ack_o[k] && add_cnt[k] > done_cnt[k]) begin
        req_r[k] = 1'b1;
      end
    end
  end

  // Drawing demux: raise de_ack ack_dly cycles into de_req, drop it one cycle after de_req falls.
  always @(posedge clk) begin
    #1;
    if (!ds_en || !rst_n) begin
      ds_ack = 1'b0;
      ds_cnt = 0;
    end else if (bus.de_req && !ds_ack) begin
      ds_cnt++;
      if (ds_cnt >= ack_dly) ds_ack = 1'b1;
    end else if (!bus.de_req && ds_ack) begin
      ds_ack = 1'b0;
      ds_cnt = 0;
    end
  end

  logic            prev_req = 1'b0;
  logic            prev_act = 1'b0;
  logic [1:0]      prev_cmd = '0;
  logic [1:0]      cap_cmd  = '0;
  logic [NREQ-1:0] prev_ack = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_req = 1'b0;
      prev_act = 1'b0;
      prev_ack = '0;
    end else begin
      if (bus.de_req && !prev_req) cap_cmd = bus.de_cmd;
      if (prev_act && (bus.de_req || bus.de_ack))
        chk("de_cmd_stable", 32'(bus.de_cmd), 32'(prev_cmd));
      chk("ack_onehot0", 32'($onehot0(bus.ack_o)), 32'd1);
      if (bus.ack_o != '0 && prev_ack == '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'(bus.ack_o), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("grant_ack", 32'(bus.ack_o), 32'(1) << e.idx);
          chk("grant_cmd", 32'(cap_cmd), 32'(e.cmd));
          chk("de_idle_at_ack", 32'({bus.de_req, bus.de_ack}), 32'd0);
          chk("busy_at_ack", 32'(bus.busy), 32'd1);
        end
      end
      prev_req = bus.de_req;
      prev_act = bus.de_req || bus.de_ack;
      prev_cmd = bus.de_cmd;
      prev_ack = bus.ack_o;
    end
  end

  task automatic request(input int k, input logic [1:0] c);
    cmd_tab[k] = c;
    add_cnt[k]++;
    sb.push_back('{k, c});
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while ((sb.size() != 0 || bus.busy || req_r != '0) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_in_time"}, 32'(n < max), 32'd1);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_de_req(input string tag);
    int n = 0;
    while (!bus.de_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_de_req_seen"}, 32'(bus.de_req), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int k = 0; k < NREQ; k++) begin
      cmd_tab[k]  = '0;
      add_cnt[k]  = 0;
      done_cnt[k] = 0;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack_o", 32'(bus.ack_o), 32'd0);
    chk("rst_de_req", 32'(bus.de_req), 32'd0);
    chk("rst_de_cmd", 32'(bus.de_cmd), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;

    // Contention from pointer 0: requester 0 re-requests and is served again after 3.
    @(negedge clk); #1;
    request(0, 2'b01);
    request(1, 2'b10);
    request(2, 2'b11);
    request(3, 2'b00);
    request(0, 2'b01);
    drain("contention", 300);

    // Pointer wrap: after 3 completes, 0 beats 3.
    #1 request(3, 2'b10);
    drain("wrap_a", 100);
    #1;
    request(0, 2'b11);
    request(3, 2'b01);
    drain("wrap_b", 200);

    // Single requester with timing checks.
    #1 request(1, 2'b11);
    n = 0;
    while (!bus.de_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("single_grant_latency", 32'(n), 32'd2);
    chk("single_de_cmd", 32'(bus.de_cmd), 32'd3);
    chk("single_busy", 32'(bus.busy), 32'd1);
    chk("single_no_early_ack", 32'(bus.ack_o), 32'd0);
    n = 0;
    while (!bus.de_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("single_de_ack_seen", 32'(bus.de_ack), 32'd1);
    @(negedge clk);
    chk("single_de_req_drop", 32'(bus.de_req), 32'd0);
    chk("single_ack_waits_deack", 32'(bus.ack_o), 32'd0);
    @(negedge clk);
    chk("single_ack_o", 32'(bus.ack_o), 32'b0010);
    drain("single", 50);
    chk("single_busy_low", 32'(bus.busy), 32'd0);

    // Late arrival: 2 rises during 1's ISSUE and is served afterwards.
    #1 request(1, 2'b01);
    wait_de_req("late");
    #1 request(2, 2'b10);
    repeat (2) @(negedge clk);
    chk("late_de_cmd_held", 32'(bus.de_cmd), 32'd1);
    drain("late", 200);

    // Reset while in ISSUE with de_ack high.
    ds_en = 1'b0;
    #1 request(2, 2'b11);
    wait_de_req("rst_mid");
    #1 hold_ack = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_de_req", 32'(bus.de_req), 32'd0);
    chk("rst_mid_ack_o", 32'(bus.ack_o), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_de_cmd", 32'(bus.de_cmd), 32'd0);
    // The interrupted grant never completes; requester 2 stays up and is re-served later.
    sb.delete();
    hold_ack = 1'b0;
    ds_en    = 1'b1;
    request(0, 2'b01);
    sb.push_back('{2, 2'b11});
    request(3, 2'b10);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drain("rst_mid", 300);

`ifdef DRAWING_ARBITER_TIMEOUT_EN
    ds_en = 1'b0;
    #1 request(1, 2'b10);
    wait_de_req("timeout");
    n = 0;
    while (bus.de_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_de_req_cycles", 32'(n), 32'(TIMEOUT));
    chk("timeout_err_set", 32'(bus.err), 32'd1);
    drain("timeout", 50);
    ds_en = 1'b1;
    #1 request(2, 2'b01);
    drain("after_timeout", 100);
    chk("timeout_err_sticky", 32'(bus.err), 32'd1);
`else
    chk("err_tied_low", 32'(bus.err), 32'd0);
`endif

    chk("final_busy", 32'(bus.busy), 32'd0);
    chk("final_ack_o", 32'(bus.ack_o), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
